// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin arbitration with wormhole locking.
// Grants, crossbar selects and output valids are combinational from the
// registered per-output state and the current requests. The sticky error
// flag is registered.
module switch_allocator #(
    parameter int unsigned N_PORTS = 5,
    parameter int unsigned PORT_W  = $clog2(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PORTS-1:0]          req_i,
    input  logic [N_PORTS*PORT_W-1:0]   out_port_i,
    input  logic [N_PORTS-1:0]          head_i,
    input  logic [N_PORTS-1:0]          tail_i,
    input  logic [N_PORTS-1:0]          out_ready_i,
    output logic [N_PORTS-1:0]          grant_o,
    output logic [N_PORTS-1:0]          out_valid_o,
    output logic [N_PORTS*PORT_W-1:0]   xbar_sel_o,
    output logic                        err_o
);

    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(N_PORTS - 1);

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            state_q [N_PORTS];
    state_e            state_d [N_PORTS];
    logic [PORT_W-1:0] owner_q [N_PORTS];
    logic [PORT_W-1:0] owner_d [N_PORTS];
    logic [PORT_W-1:0] rr_q    [N_PORTS];
    logic [PORT_W-1:0] rr_d    [N_PORTS];
    logic              err_q;
    logic              err_d;

    logic [PORT_W-1:0] port_of [N_PORTS];

    // Unpack the per-input target port fields.
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            port_of[i] = out_port_i[i*PORT_W +: PORT_W];
        end
    end

    // Per-output arbitration, grant generation and next-state computation.
    always_comb begin
        logic              found;
        logic [PORT_W-1:0] win;
        logic [PORT_W-1:0] idx;

        grant_o     = '0;
        out_valid_o = '0;
        xbar_sel_o  = '0;
        err_d       = err_q;
        found       = 1'b0;
        win         = '0;
        idx         = '0;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
        end

        // A request naming a port that does not exist can never be served.
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (req_i[i] && (port_of[i] > LAST_PORT)) begin
                err_d = 1'b1;
            end
        end

        for (int unsigned o = 0; o < N_PORTS; o++) begin
            found = 1'b0;
            win   = '0;

            if (state_q[o] == ST_LOCKED) begin
                // Only the owner may continue; a new head from it is illegal.
                if (req_i[owner_q[o]] && (port_of[owner_q[o]] == PORT_W'(o))) begin
                    if (head_i[owner_q[o]]) begin
                        err_d = 1'b1;
                    end else begin
                        found = 1'b1;
                        win   = owner_q[o];
                    end
                end
            end else begin
                // Body flits may not open a packet on an idle output.
                for (int unsigned i = 0; i < N_PORTS; i++) begin
                    if (req_i[i] && !head_i[i] && (port_of[i] == PORT_W'(o))) begin
                        err_d = 1'b1;
                    end
                end
                // Round-robin search starting at the pointer, wrapping.
                idx = rr_q[o];
                for (int unsigned k = 0; k < N_PORTS; k++) begin
                    if (!found && req_i[idx] && head_i[idx] && (port_of[idx] == PORT_W'(o))) begin
                        found = 1'b1;
                        win   = idx;
                    end
                    idx = (idx == LAST_PORT) ? '0 : idx + PORT_W'(1);
                end
            end

            if (found && out_ready_i[o]) begin
                grant_o[win]                      = 1'b1;
                out_valid_o[o]                    = 1'b1;
                xbar_sel_o[o*PORT_W +: PORT_W]    = win;
                if (state_q[o] == ST_FREE) begin
                    rr_d[o] = (win == LAST_PORT) ? '0 : win + PORT_W'(1);
                    if (!tail_i[win]) begin
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = win;
                    end
                end else if (tail_i[win]) begin
                    state_d[o] = ST_FREE;
                end
            end
        end
    end

    // State, owner, pointer and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < N_PORTS; o++) begin
                state_q[o] <= ST_FREE;
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned o = 0; o < N_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
            end
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus randomized legal
// packet traffic, compared against a behavioural allocator model.
module tb_switch_allocator;

    localparam int N  = 5;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_i;
    logic [N*PW-1:0] out_port_i;
    logic [N-1:0]    head_i;
    logic [N-1:0]    tail_i;
    logic [N-1:0]    out_ready_i;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    out_valid_o;
    logic [N*PW-1:0] xbar_sel_o;
    logic            err_o;

    always #5 clk = ~clk;

    switch_allocator #(.N_PORTS(N), .PORT_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .out_port_i  (out_port_i),
        .head_i      (head_i),
        .tail_i      (tail_i),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .out_valid_o (out_valid_o),
        .xbar_sel_o  (xbar_sel_o),
        .err_o       (err_o)
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus for the current cycle.
    int t_req[N], t_port[N], t_head[N], t_tail[N], t_ready[N];

    // Model state: lock flag, owner and round-robin pointer per output.
    int m_locked[N], m_owner[N], m_rr[N], m_err;
    int n_locked[N], n_owner[N], n_rr[N], n_err;

    logic [N-1:0]    e_grant;
    logic [N-1:0]    e_valid;
    logic [N*PW-1:0] e_sel;
    logic            e_err;

    // Random traffic generators.
    int g_rem[N], g_port[N], g_first[N];
    int bp_grants;

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            t_req[i]   = 0;
            t_port[i]  = 0;
            t_head[i]  = 0;
            t_tail[i]  = 0;
            t_ready[i] = 1;
        end
    endtask

    task automatic send(int i, int port, int head, int tail);
        t_req[i]  = 1;
        t_port[i] = port;
        t_head[i] = head;
        t_tail[i] = tail;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_i[i]                = (t_req[i] != 0);
            out_port_i[i*PW +: PW]  = PW'(t_port[i]);
            head_i[i]               = (t_head[i] != 0);
            tail_i[i]               = (t_tail[i] != 0);
            out_ready_i[i]          = (t_ready[i] != 0);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_locked[o] = 0;
            m_owner[o]  = 0;
            m_rr[o]     = 0;
        end
        m_err = 0;
    endtask

    // Expected outputs and next state from the allocation rules.
    task automatic model_eval();
        e_grant = '0;
        e_valid = '0;
        e_sel   = '0;
        e_err   = (m_err != 0);
        n_err   = m_err;
        for (int o = 0; o < N; o++) begin
            n_locked[o] = m_locked[o];
            n_owner[o]  = m_owner[o];
            n_rr[o]     = m_rr[o];
        end
        for (int i = 0; i < N; i++) begin
            if (t_req[i] != 0 && t_port[i] >= N) n_err = 1;
        end
        for (int o = 0; o < N; o++) begin
            int w;
            w = -1;
            if (m_locked[o] != 0) begin
                int ow;
                ow = m_owner[o];
                if (t_req[ow] != 0 && t_port[ow] == o) begin
                    if (t_head[ow] != 0) n_err = 1;
                    else w = ow;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (t_req[i] != 0 && t_port[i] == o && t_head[i] == 0) n_err = 1;
                end
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr[o] + k) % N;
                    if (w < 0 && t_req[c] != 0 && t_head[c] != 0 && t_port[c] == o) w = c;
                end
            end
            if (w >= 0 && t_ready[o] != 0) begin
                e_grant[w]          = 1'b1;
                e_valid[o]          = 1'b1;
                e_sel[o*PW +: PW]   = PW'(w);
                if (m_locked[o] == 0) begin
                    n_rr[o] = (w + 1) % N;
                    if (t_tail[w] == 0) begin
                        n_locked[o] = 1;
                        n_owner[o]  = w;
                    end
                end else if (t_tail[w] != 0) begin
                    n_locked[o] = 0;
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int o = 0; o < N; o++) begin
            m_locked[o] = n_locked[o];
            m_owner[o]  = n_owner[o];
            m_rr[o]     = n_rr[o];
        end
        m_err = n_err;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive, settle, and compare all outputs with the model.
    task automatic eval_check(string tag);
        drive();
        #1;
        model_eval();
        chk({tag, " grant"}, 32'(grant_o), 32'(e_grant));
        chk({tag, " valid"}, 32'(out_valid_o), 32'(e_valid));
        chk({tag, " xsel"}, 32'(xbar_sel_o), 32'(e_sel));
        chk({tag, " err"}, 32'(err_o), 32'(e_err));
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        drive();
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order[6];
        order = '{0, 3, 4, 0, 3, 4};

        rst_n = 1'b0;
        clear_inputs();
        drive();
        model_reset();
        #12;
        chk("reset grant", 32'(grant_o), 32'h0);
        chk("reset valid", 32'(out_valid_o), 32'h0);
        chk("reset xsel", 32'(xbar_sel_o), 32'h0);
        chk("reset err", 32'(err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-flit packet from input 1 to port 2.
        clear_inputs();
        send(1, 2, 1, 1);
        eval_check("single");
        chk("single grant_c", 32'(grant_o), 32'b00010);
        chk("single valid2", 32'(out_valid_o[2]), 32'h1);
        chk("single sel2", 32'(xbar_sel_o[2*PW +: PW]), 32'h1);
        advance();
        // Pointer of port 2 now at 2: input 3 beats input 0.
        clear_inputs();
        send(0, 2, 1, 1);
        send(3, 2, 1, 1);
        eval_check("rrptr2");
        chk("rrptr2 grant_c", 32'(grant_o), 32'b01000);
        advance();

        // Round-robin among inputs 0, 3, 4 on port 1.
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            send(0, 1, 1, 1);
            send(3, 1, 1, 1);
            send(4, 1, 1, 1);
            eval_check("rr");
            chk("rr order", 32'(grant_o), 32'(1) << order[k]);
            advance();
        end

        // Move port 3 pointer past input 0 so input 2 wins the lock.
        clear_inputs();
        send(1, 3, 1, 1);
        eval_check("pre_worm");
        advance();

        // Wormhole: input 2 four flits to port 3, input 0 head waits.
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            send(0, 3, 1, 1);
            if (k < 4) send(2, 3, (k == 0) ? 1 : 0, (k == 3) ? 1 : 0);
            eval_check("worm");
            chk("worm grant_c", 32'(grant_o), (k < 4) ? 32'b00100 : 32'b00001);
            advance();
        end

        // Backpressure mid-packet on port 3.
        bp_grants = 0;
        begin
            int fl;
            fl = 0;
            for (int k = 0; k < 7; k++) begin
                clear_inputs();
                send(2, 3, (fl == 0) ? 1 : 0, (fl == 3) ? 1 : 0);
                t_ready[3] = (k >= 2 && k <= 4) ? 0 : 1;
                eval_check("bp");
                if (k >= 2 && k <= 4) chk("bp stall", 32'(grant_o), 32'h0);
                bp_grants += int'(grant_o[2]);
                if (grant_o[2]) fl++;
                advance();
            end
        end
        chk("bp total", 32'(bp_grants), 32'd4);

        // Parallel grants on different outputs.
        clear_inputs();
        send(0, 4, 1, 1);
        send(1, 0, 1, 1);
        eval_check("par");
        chk("par grant_c", 32'(grant_o), 32'b00011);
        advance();

        // Body flit to a free output raises the sticky error.
        clear_inputs();
        send(3, 2, 0, 0);
        eval_check("bodyfree");
        chk("bodyfree grant_c", 32'(grant_o), 32'h0);
        advance();
        clear_inputs();
        eval_check("err_set");
        chk("err_set c", 32'(err_o), 32'h1);
        advance();

        // Lock port 3, then reset asynchronously mid-packet.
        clear_inputs();
        send(2, 3, 1, 0);
        eval_check("lock3");
        advance();
        clear_inputs();
        drive();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async err", 32'(err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_inputs();
        send(0, 3, 1, 1);
        eval_check("fresh");
        chk("fresh grant_c", 32'(grant_o), 32'b00001);
        advance();

        // Nonexistent target port.
        clear_inputs();
        send(1, 7, 1, 1);
        eval_check("badport");
        chk("badport grant_c", 32'(grant_o), 32'h0);
        advance();
        clear_inputs();
        eval_check("badport_err");
        chk("badport err_c", 32'(err_o), 32'h1);
        advance();

        // Randomized legal packet traffic.
        do_reset();
        for (int i = 0; i < N; i++) begin
            g_rem[i]   = 0;
            g_port[i]  = 0;
            g_first[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_inputs();
            for (int i = 0; i < N; i++) begin
                if (g_rem[i] == 0 && $urandom_range(0, 1) == 1) begin
                    g_rem[i]   = int'($urandom_range(1, 4));
                    g_port[i]  = int'($urandom_range(0, N - 1));
                    g_first[i] = 1;
                end
                t_req[i]  = (g_rem[i] > 0) ? 1 : 0;
                t_port[i] = g_port[i];
                t_head[i] = (g_rem[i] > 0 && g_first[i] != 0) ? 1 : 0;
                t_tail[i] = (g_rem[i] == 1) ? 1 : 0;
            end
            for (int o = 0; o < N; o++) begin
                t_ready[o] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            end
            eval_check("rand");
            for (int i = 0; i < N; i++) begin
                if (e_grant[i]) begin
                    g_rem[i]   = g_rem[i] - 1;
                    g_first[i] = 0;
                end
            end
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
